wb_timer: RTL and testbench

Memory-mapped timer peripheral that sits on the CPU's 32-bit strobe/acknowledge data bus as a responder. It decodes a 16-byte register window, answers reads and writes with a registered four-phase acknowledge, and counts down a prescaled 32-bit counter. On expiry it raises an interrupt line intended for the CPU `irq` input.

---
 rtl/wb_timer.sv | 165 ++++++++++++++++
 tb/tb_wb_timer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_timer.sv
// Strobe/acknowledge bus responder with a four-register prescaled down-counter timer.
// Accesses are performed once on entry to ACK; the timer raises irq_o when PEND and IE are both set.
module wb_timer #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        irq_o
);
  // Bus handshake: the initiator holds stb_i and the address/data stable until it
  // sees ack_o = 1, then drops stb_i; ack_o falls on the first edge sampling stb_i = 0.
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam bit         NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [3:0] WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        en, ie, auto_rl, pend;
  logic [15:0] presc, pre_cnt;
  logic [31:0] load, count;

  logic        hit, go_ack, wr_commit;
  logic        wr_ctrl, wr_load, wr_count, wr_status;
  logic        tick, expiry, en_rise, pend_clr;
  logic [31:0] wmask, ctrl_val, ctrl_new, load_new, count_new, rd_val;
  logic        unused_ok;

  assign hit    = (adr_i[31:4] == BASE_ADDR[31:4]);
  assign go_ack = stb_i && (((state == IDLE) && hit && NO_WAIT) ||
                            ((state == WAIT) && (wait_cnt == 4'd0)));
  assign wr_commit = go_ack && we_i;

  assign wr_ctrl   = wr_commit && (adr_i[3:2] == 2'd0);
  assign wr_load   = wr_commit && (adr_i[3:2] == 2'd1);
  assign wr_count  = wr_commit && (adr_i[3:2] == 2'd2);
  assign wr_status = wr_commit && (adr_i[3:2] == 2'd3);

  assign wmask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};

  assign ctrl_val  = {presc, 13'd0, auto_rl, ie, en};
  assign ctrl_new  = (ctrl_val & ~wmask) | (dat_i & wmask);
  assign load_new  = (load & ~wmask) | (dat_i & wmask);
  assign count_new = (count & ~wmask) | (dat_i & wmask);

  assign en_rise  = wr_ctrl && !en && ctrl_new[0];
  assign pend_clr = wr_status && sel_i[0] && dat_i[0];

  // The prescaler only runs while there is something left to count down.
  assign tick   = en && (count != 32'd0) && (pre_cnt == presc);
  assign expiry = tick && (count == 32'd1);

  always_comb begin
    rd_val = 32'd0;
    case (adr_i[3:2])
      2'd0: rd_val = ctrl_val;
      2'd1: rd_val = load;
      2'd2: rd_val = count;
      2'd3: rd_val = {31'd0, pend};
      default: rd_val = 32'd0;
    endcase
  end

  assign irq_o     = pend & ie;
  assign unused_ok = ^{adr_i[1:0], ctrl_new[15:3]};

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      ack_o    <= 1'b0;
      dat_o    <= 32'd0;
      en       <= 1'b0;
      ie       <= 1'b0;
      auto_rl  <= 1'b0;
      presc    <= 16'd0;
      pre_cnt  <= 16'd0;
      load     <= 32'd0;
      count    <= 32'd0;
      pend     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (stb_i && hit) begin
            if (NO_WAIT) begin
              state <= ACK;
              ack_o <= 1'b1;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (!stb_i) begin
            state <= IDLE;
          end else if (wait_cnt == 4'd0) begin
            state <= ACK;
            ack_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ACK: begin
          if (!stb_i) begin
            state <= IDLE;
            ack_o <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ack_o <= 1'b0;
        end
      endcase

      if (go_ack && !we_i) dat_o <= rd_val;

      if (en && (count != 32'd0)) begin
        if (tick) begin
          pre_cnt <= 16'd0;
          if (expiry) begin
            if (auto_rl) begin
              count <= load;
            end else begin
              count <= 32'd0;
              en    <= 1'b0;
            end
          end else begin
            count <= count - 32'd1;
          end
        end else begin
          pre_cnt <= pre_cnt + 16'd1;
        end
      end

      // Expiry outranks a simultaneous software clear.
      pend <= expiry | (pend & ~pend_clr);

      // Bus writes come last so they override the counter update of the same edge.
      if (wr_ctrl) begin
        en      <= ctrl_new[0];
        ie      <= ctrl_new[1];
        auto_rl <= ctrl_new[2];
        presc   <= ctrl_new[31:16];
        if (en_rise) begin
          count   <= load;
          pre_cnt <= 16'd0;
        end
      end
      if (wr_load) load <= load_new;
      if (wr_count) begin
        count   <= count_new;
        pre_cnt <= 16'd0;
      end
    end
  end
endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: a register-access vector table plus hand-timed
// sequences for counter expiry, auto-reload, collisions, wait states and aborts.
module tb_wb_timer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, we = 1'b0;
  logic [31:0] adr = 32'd0, dat_w = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic        which = 1'b0;
  logic        stb0, stb2, ack0, ack2, irq0, irq2, ack;
  logic [31:0] dat0, dat2, dat_r;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int ack_cyc;
  logic irq_at_ack;

  assign stb0  = stb && !which;
  assign stb2  = stb && which;
  assign ack   = which ? ack2 : ack0;
  assign dat_r = which ? dat2 : dat0;

  wb_timer #(.BASE_ADDR(32'hFFFF_0000), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_i(rst), .stb_i(stb0), .we_i(we), .adr_i(adr), .sel_i(sel),
    .dat_i(dat_w), .dat_o(dat0), .ack_o(ack0), .irq_o(irq0));

  wb_timer #(.BASE_ADDR(32'hFFFF_0000), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst_i(rst), .stb_i(stb2), .we_i(we), .adr_i(adr), .sel_i(sel),
    .dat_i(dat_w), .dat_o(dat2), .ack_o(ack2), .irq_o(irq2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete access; returns read data and acknowledge latency in edges.
  task automatic bus_access(input logic w, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d, input int hold,
                            output logic [31:0] rd, output int lat);
    int n;
    bit got;
    @(negedge clk);
    stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    n = 0; got = 0;
    while (!got && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (ack) got = 1;
    end
    lat = n; rd = dat_r; ack_cyc = cyc; irq_at_ack = irq0;
    if (!got) check("ack_timeout", 32'(ack), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("ack_hold", 32'(ack), 32'd1);
      check("dat_hold", dat_r, rd);
    end
    @(negedge clk);
    stb = 1'b0;
    @(posedge clk); #1;
    check("ack_release", 32'(ack), 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int exp_lat);
    logic [31:0] rd;
    int lat;
    bus_access(1'b1, a, s, d, 0, rd, lat);
    check("wr_latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp, input int exp_lat);
    logic [31:0] rd;
    int lat;
    bus_access(1'b0, a, 4'hF, 32'd0, 0, rd, lat);
    check(name, rd, exp);
    check("rd_latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic wait_irq(output int c);
    int n;
    n = 0; c = -1;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (irq0) begin
        c = cyc;
        break;
      end
    end
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] rd;
    int lat, c0, c1, flag;

    vecs[0]  = '{1'b0, 32'hFFFF_0000, 4'hF, 32'h0,         1'b1, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'hFFFF_0004, 4'hF, 32'h0,         1'b1, 32'h0000_0000};
    vecs[2]  = '{1'b0, 32'hFFFF_0008, 4'hF, 32'h0,         1'b1, 32'h0000_0000};
    vecs[3]  = '{1'b0, 32'hFFFF_000C, 4'hF, 32'h0,         1'b1, 32'h0000_0000};
    vecs[4]  = '{1'b1, 32'hFFFF_0004, 4'hF, 32'hAABB_CCDD, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'hFFFF_0004, 4'h2, 32'h1122_3344, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'hFFFF_0004, 4'hF, 32'h0,         1'b1, 32'hAABB_33DD};
    vecs[7]  = '{1'b1, 32'hFFFF_0000, 4'hF, 32'hFFFF_FFF6, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'hFFFF_0000, 4'hF, 32'h0,         1'b1, 32'hFFFF_0006};
    vecs[9]  = '{1'b1, 32'hFFFF_0008, 4'hC, 32'h1234_5678, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'hFFFF_0008, 4'hF, 32'h0,         1'b1, 32'h1234_0000};
    vecs[11] = '{1'b1, 32'hFFFF_0000, 4'h1, 32'h0000_0000, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 32'hFFFF_0000, 4'hF, 32'h0,         1'b1, 32'hFFFF_0000};
    vecs[13] = '{1'b1, 32'hFFFF_0000, 4'hC, 32'h0000_0000, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 32'hFFFF_0000, 4'hF, 32'h0,         1'b1, 32'h0000_0000};
    vecs[15] = '{1'b0, 32'hFFFF_0006, 4'hF, 32'h0,         1'b1, 32'hAABB_33DD};

    // Clock/reset: reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack2", 32'(ack2), 32'd0);
    check("rst_dat0", dat0, 32'd0);
    check("rst_irq0", 32'(irq0), 32'd0);
    check("rst_irq2", 32'(irq2), 32'd0);

    // Register access table on the zero-wait instance.
    which = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus_access(vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, (i == 0) ? 2 : 0, rd, lat);
      check("vec_latency", 32'(lat), 32'd1);
      if (vecs[i].chk) begin
        if (rd !== vecs[i].exp) $display("  vector %0d", i);
        check("vec_data", rd, vecs[i].exp);
      end
    end

    // Auto-reload: expiry every 5 cycles, clear drops irq on the next edge.
    wr(32'hFFFF_0004, 32'd5, 4'hF, 1);
    wr(32'hFFFF_0000, 32'h0000_0007, 4'hF, 1);
    c0 = ack_cyc;
    wait_irq(c1);
    check("auto_first_expiry", 32'(c1 - c0), 32'd5);
    wr(32'hFFFF_000C, 32'd1, 4'h1, 1);
    check("auto_clear_cycle", 32'(ack_cyc - c0), 32'd6);
    check("auto_clear_irq", 32'(irq_at_ack), 32'd0);
    wait_irq(c1);
    check("auto_second_expiry", 32'(c1 - c0), 32'd10);
    wr(32'hFFFF_0000, 32'd0, 4'hF, 1);
    wr(32'hFFFF_000C, 32'd1, 4'h1, 1);
    check("stop_irq", 32'(irq0), 32'd0);

    // One-shot with PRESC = 1.
    wr(32'hFFFF_0004, 32'd3, 4'hF, 1);
    wr(32'hFFFF_0000, 32'h0001_0003, 4'hF, 1);
    c0 = ack_cyc;
    wait_irq(c1);
    check("oneshot_expiry", 32'(c1 - c0), 32'd6);
    rd_chk("oneshot_ctrl", 32'hFFFF_0000, 32'h0001_0002, 1);
    rd_chk("oneshot_count", 32'hFFFF_0008, 32'h0000_0000, 1);
    rd_chk("oneshot_status", 32'hFFFF_000C, 32'h0000_0001, 1);

    // Collision: STATUS clear committed on the expiry edge.
    wr(32'hFFFF_000C, 32'd1, 4'h1, 1);
    wr(32'hFFFF_0004, 32'd10, 4'hF, 1);
    wr(32'hFFFF_0000, 32'h0000_0003, 4'hF, 1);
    c0 = ack_cyc;
    flag = 0;
    while (cyc < c0 + 9 && flag < 40) begin
      @(posedge clk); #1;
      flag++;
    end
    check("coll_pre_irq", 32'(irq0), 32'd0);
    wr(32'hFFFF_000C, 32'd1, 4'h1, 1);
    check("coll_cycle", 32'(ack_cyc - c0), 32'd10);
    check("coll_irq_at_commit", 32'(irq_at_ack), 32'd1);
    check("coll_irq_after", 32'(irq0), 32'd1);
    rd_chk("coll_status", 32'hFFFF_000C, 32'h0000_0001, 1);

    // Wait-state instance.
    which = 1'b1;
    rd_chk("ws_read_ctrl", 32'hFFFF_0000, 32'h0000_0000, 3);

    @(negedge clk);
    stb = 1'b1; we = 1'b0; adr = 32'h0000_0000; sel = 4'hF;
    flag = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ack) flag = 1;
    end
    check("ws_unselected_noack", 32'(flag), 32'd0);
    @(negedge clk);
    stb = 1'b0;

    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = 32'hFFFF_0004; sel = 4'hF; dat_w = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    check("ws_abort_ack_a", 32'(ack), 32'd0);
    @(negedge clk);
    stb = 1'b0;
    flag = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) flag = 1;
    end
    check("ws_abort_ack_b", 32'(flag), 32'd0);
    rd_chk("ws_abort_load", 32'hFFFF_0004, 32'h0000_0000, 3);
    wr(32'hFFFF_0004, 32'h0BAD_F00D, 4'hF, 3);
    rd_chk("ws_load", 32'hFFFF_0004, 32'h0BAD_F00D, 3);

    // Reset while ACK is held drops ack_o on that edge.
    which = 1'b0;
    @(negedge clk);
    stb = 1'b1; we = 1'b0; adr = 32'hFFFF_0004; sel = 4'hF;
    @(posedge clk); #1;
    check("rst_in_ack_pre", 32'(ack), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ack_ack", 32'(ack), 32'd0);
    check("rst_in_ack_dat", dat_r, 32'd0);
    @(negedge clk);
    rst = 1'b0; stb = 1'b0;
    rd_chk("rst_in_ack_load", 32'hFFFF_0004, 32'h0000_0000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
